// File: rtl/mc_controller_if.sv
// Control/handshake bundle between the multi-cycle MIPS controller and its datapath.
// The controller uses the master modport; the datapath side uses the slave modport.
interface mc_controller_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       func;
    logic             zero;
    logic             mem_ready;
    logic             pcWrite;
    logic             IorD;
    logic             memRead;
    logic             memWrite;
    logic             IRWrite;
    logic             regWrite;
    logic [1:0]       regIn;
    logic [1:0]       toReg;
    logic [1:0]       pcIn;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       ALUcntrl;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, func, zero, mem_ready,
        output pcWrite, IorD, memRead, memWrite, IRWrite, regWrite,
               regIn, toReg, pcIn, aluSrcA, aluSrcB, ALUcntrl, illegal, retired
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  pcWrite, IorD, memRead, memWrite, IRWrite, regWrite,
               regIn, toReg, pcIn, aluSrcA, aluSrcB, ALUcntrl, illegal, retired
    );
endinterface

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing,
// memory-ready stalls, illegal-opcode pulse and retired-instruction counter.
// Control outputs are registered from the next state, so they always reflect the
// current state; only the FETCH (mem_ready) and BRANCH (zero) enables are gated live.
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    mc_controller_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EX     = 4'd6,
        R_WB     = 4'd7,
        I_EX     = 4'd8,
        I_WB     = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;   // unconditional PC load
        logic       fetch;      // IRWrite/pcWrite follow mem_ready
        logic       branch;     // pcWrite follows the branch condition
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_in;
        logic [1:0] to_reg;
        logic [1:0] pc_in;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ctrl;
    } ctrl_t;

    state_t           state_r;
    state_t           next_s;
    ctrl_t            ctrl_r;
    logic             illegal_r;
    logic [CNT_W-1:0] retired_r;
    logic             is_bne_s;

    // Moore control word for a state; op only selects add vs slt in I_EX.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
            DECODE:   begin c.alu_src_b = 2'd3; end
            MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            MEM_RD:   begin c.iord = 1'b1; c.mem_read = 1'b1; end
            MEM_WB:   begin c.reg_write = 1'b1; c.reg_in = 2'd0; c.to_reg = 2'd1; end
            MEM_WR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
            R_EX:     begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd0; c.alu_ctrl = 2'd2; end
            R_WB:     begin c.reg_write = 1'b1; c.reg_in = 2'd1; c.to_reg = 2'd0; end
            I_EX:     begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
                c.alu_ctrl  = (op == OP_SLTI) ? 2'd3 : 2'd0;
            end
            I_WB:     begin c.reg_write = 1'b1; c.reg_in = 2'd0; c.to_reg = 2'd0; end
            BRANCH:   begin c.branch = 1'b1; c.alu_src_a = 1'b1; c.alu_ctrl = 2'd1; c.pc_in = 2'd3; end
            JUMP:     begin c.pc_write = 1'b1; c.pc_in = 2'd1; end
            JAL:      begin
                c.pc_write  = 1'b1;
                c.pc_in     = 2'd1;
                c.reg_write = 1'b1;
                c.reg_in    = 2'd2;
                c.to_reg    = 2'd2;
            end
            JR:       begin c.pc_write = 1'b1; c.pc_in = 2'd2; end
            default:  begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'd1; end
        endcase
        return c;
    endfunction

    // Successor state; unused encodings fall back to FETCH.
    function automatic state_t next_of(input state_t s, input logic [5:0] op,
                                       input logic [5:0] fn, input logic rdy);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:    n = rdy ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_RTYPE:       n = (fn == FN_JR) ? JR : R_EX;
                    OP_LW, OP_SW:   n = MEM_ADDR;
                    OP_BEQ, OP_BNE: n = BRANCH;
                    OP_ADDI, OP_SLTI: n = I_EX;
                    OP_J:           n = JUMP;
                    OP_JAL:         n = JAL;
                    default:        n = FETCH;
                endcase
            end
            MEM_ADDR: n = (op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   n = rdy ? MEM_WB : MEM_RD;
            MEM_WR:   n = rdy ? FETCH : MEM_WR;
            R_EX:     n = R_WB;
            I_EX:     n = I_WB;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

    // Opcodes the datapath can execute.
    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_SLTI, OP_LW, OP_SW: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // States that complete an instruction when they hand back to FETCH.
    function automatic logic is_last(input state_t s);
        logic last;
        case (s)
            MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JAL, JR: last = 1'b1;
            default:                                          last = 1'b0;
        endcase
        return last;
    endfunction

    assign next_s   = next_of(state_r, bus.opcode, bus.func, bus.mem_ready);
    assign is_bne_s = (bus.opcode == OP_BNE);

    // State, registered control word, illegal pulse and retired counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= FETCH;
            ctrl_r    <= ctrl_of(FETCH, OP_RTYPE);
            illegal_r <= 1'b0;
            retired_r <= '0;
        end else begin
            state_r   <= next_s;
            ctrl_r    <= ctrl_of(next_s, bus.opcode);
            illegal_r <= (state_r == DECODE) && !is_legal(bus.opcode);
            if (is_last(state_r) && (next_s == FETCH)) begin
                retired_r <= retired_r + CNT_ONE;
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    assign bus.pcWrite  = ctrl_r.pc_write
                        | (ctrl_r.fetch  & bus.mem_ready)
                        | (ctrl_r.branch & (bus.zero ^ is_bne_s));
    assign bus.IRWrite  = ctrl_r.fetch & bus.mem_ready;
    assign bus.IorD     = ctrl_r.iord;
    assign bus.memRead  = ctrl_r.mem_read;
    assign bus.memWrite = ctrl_r.mem_write;
    assign bus.regWrite = ctrl_r.reg_write;
    assign bus.regIn    = ctrl_r.reg_in;
    assign bus.toReg    = ctrl_r.to_reg;
    assign bus.pcIn     = ctrl_r.pc_in;
    assign bus.aluSrcA  = ctrl_r.alu_src_a;
    assign bus.aluSrcB  = ctrl_r.alu_src_b;
    assign bus.ALUcntrl = ctrl_r.alu_ctrl;
    assign bus.illegal  = illegal_r;
    assign bus.retired  = retired_r;
endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: each instruction is expanded into a list of
// expected control phases taken from the instruction-class tables, then driven with
// random memory-wait patterns and compared cycle by cycle.
module tb_mc_controller;
    localparam int CNT_W    = 4;
    localparam int K_PLAIN  = 0;
    localparam int K_FETCH  = 1;
    localparam int K_BRANCH = 2;

    typedef struct {
        logic [16:0] v;
        int          kind;
        bit          waits;
    } phase_t;

    logic clk;
    logic rst;
    mc_controller_if #(.CNT_W(CNT_W)) bus();
    mc_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks    = 0;
    int passes    = 0;
    int retired_m = 0;
    bit pend_illegal = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcWrite,IorD,memRead,memWrite,IRWrite,regWrite,regIn,toReg,pcIn,aluSrcA,aluSrcB,ALUcntrl}
    function automatic logic [16:0] mk(input int pcw, input int iord, input int mr, input int mw,
                                       input int irw, input int rw, input int ri, input int tr,
                                       input int pci, input int asa, input int asb, input int alu);
        return {1'(pcw), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rw),
                2'(ri), 2'(tr), 2'(pci), 1'(asa), 2'(asb), 2'(alu)};
    endfunction

    function automatic phase_t mkp(input logic [16:0] v, input int kind, input bit waits);
        phase_t p;
        p.v = v; p.kind = kind; p.waits = waits;
        return p;
    endfunction

    function automatic logic [17:0] observe();
        return {bus.pcWrite, bus.IorD, bus.memRead, bus.memWrite, bus.IRWrite, bus.regWrite,
                bus.regIn, bus.toReg, bus.pcIn, bus.aluSrcA, bus.aluSrcB, bus.ALUcntrl,
                bus.illegal};
    endfunction

    // Run one instruction from its first FETCH cycle back to the next FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw, input string tag);
        phase_t      ph[$];
        logic [16:0] ev;
        logic [17:0] exp_all;
        logic [17:0] got;
        logic        rdy;
        bit          legal;
        int          nw;
        legal = 1'b1;
        ph.push_back(mkp(mk(0,0,1,0,0,0,0,0,0,0,1,0), K_FETCH, 1'b1));
        ph.push_back(mkp(mk(0,0,0,0,0,0,0,0,0,0,3,0), K_PLAIN, 1'b0));
        if (op == 6'b000000 && fn == 6'b001000) begin
            ph.push_back(mkp(mk(1,0,0,0,0,0,0,0,2,0,0,0), K_PLAIN, 1'b0));
        end else if (op == 6'b000000) begin
            ph.push_back(mkp(mk(0,0,0,0,0,0,0,0,0,1,0,2), K_PLAIN, 1'b0));
            ph.push_back(mkp(mk(0,0,0,0,0,1,1,0,0,0,0,0), K_PLAIN, 1'b0));
        end else if (op == 6'b100011) begin
            ph.push_back(mkp(mk(0,0,0,0,0,0,0,0,0,1,2,0), K_PLAIN, 1'b0));
            ph.push_back(mkp(mk(0,1,1,0,0,0,0,0,0,0,0,0), K_PLAIN, 1'b1));
            ph.push_back(mkp(mk(0,0,0,0,0,1,0,1,0,0,0,0), K_PLAIN, 1'b0));
        end else if (op == 6'b101011) begin
            ph.push_back(mkp(mk(0,0,0,0,0,0,0,0,0,1,2,0), K_PLAIN, 1'b0));
            ph.push_back(mkp(mk(0,1,0,1,0,0,0,0,0,0,0,0), K_PLAIN, 1'b1));
        end else if (op == 6'b000100 || op == 6'b000101) begin
            ph.push_back(mkp(mk(0,0,0,0,0,0,0,0,3,1,0,1), K_BRANCH, 1'b0));
        end else if (op == 6'b001000 || op == 6'b001010) begin
            ph.push_back(mkp(mk(0,0,0,0,0,0,0,0,0,1,2,(op == 6'b001010) ? 3 : 0), K_PLAIN, 1'b0));
            ph.push_back(mkp(mk(0,0,0,0,0,1,0,0,0,0,0,0), K_PLAIN, 1'b0));
        end else if (op == 6'b000010) begin
            ph.push_back(mkp(mk(1,0,0,0,0,0,0,0,1,0,0,0), K_PLAIN, 1'b0));
        end else if (op == 6'b000011) begin
            ph.push_back(mkp(mk(1,0,0,0,0,1,2,2,1,0,0,0), K_PLAIN, 1'b0));
        end else begin
            legal = 1'b0;
        end
        bus.opcode = op;
        bus.func   = fn;
        for (int p = 0; p < ph.size(); p++) begin
            nw = ph[p].waits ? ((ph[p].kind == K_FETCH) ? fw : mw) : 0;
            for (int w = 0; w <= nw; w++) begin
                rdy = ph[p].waits ? (w == nw) : 1'($urandom);
                bus.mem_ready = rdy;
                bus.zero      = (ph[p].kind == K_BRANCH) ? z : 1'($urandom);
                #1;
                ev = ph[p].v;
                if (ph[p].kind == K_FETCH) begin
                    ev[16] = rdy;
                    ev[12] = rdy;
                end else if (ph[p].kind == K_BRANCH) begin
                    ev[16] = z ^ (op == 6'b000101);
                end
                exp_all = {ev, (p == 0 && w == 0) ? pend_illegal : 1'b0};
                got = observe();
                checks++;
                if (got !== exp_all) begin
                    $display("FAIL %s phase%0d wait%0d: controls got %h expected %h",
                             tag, p, w, got, exp_all);
                end else begin
                    passes++;
                end
                if (p == 0 && w == 0) begin
                    checks++;
                    if (bus.retired !== CNT_W'(retired_m)) begin
                        $display("FAIL %s retired: got %0d expected %0d",
                                 tag, bus.retired, retired_m);
                    end else begin
                        passes++;
                    end
                end
                @(negedge clk);
            end
        end
        if (legal) begin
            retired_m = (retired_m + 1) % (1 << CNT_W);
        end
        pend_illegal = !legal;
    endtask

    task automatic test_reset();
        logic [16:0] ev;
        rst = 1'b1;
        bus.opcode = 6'd0; bus.func = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        ev = mk(0,0,1,0,0,0,0,0,0,0,1,0);
        checks++;
        if (observe() !== {ev, 1'b0}) begin
            $display("FAIL reset_fetch: got %h expected %h", observe(), {ev, 1'b0});
        end else begin
            passes++;
        end
        checks++;
        if (bus.retired !== 4'd0) begin
            $display("FAIL reset_retired: got %0d expected 0", bus.retired);
        end else begin
            passes++;
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        ev[16] = 1'b1;
        ev[12] = 1'b1;
        checks++;
        if (observe() !== {ev, 1'b0}) begin
            $display("FAIL reset_fetch_ready: got %h expected %h", observe(), {ev, 1'b0});
        end else begin
            passes++;
        end
        bus.mem_ready = 1'b0;
        rst = 1'b0;
        retired_m = 0;
        pend_illegal = 1'b0;
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "rtype_add");
        checks++;
        if (bus.retired !== 4'd1) begin
            $display("FAIL rtype_retired: got %0d expected 1", bus.retired);
        end else begin
            passes++;
        end
    endtask

    task automatic test_lw_wait();
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, "lw_wait2");
        run_instr(6'b100011, 6'b000000, 1'b0, 1, 0, "lw_fetchwait");
    endtask

    task automatic test_itype();
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, "addi");
        run_instr(6'b001010, 6'b000000, 1'b0, 0, 0, "slti");
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 3, "sw_wait3");
    endtask

    task automatic test_branch();
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_taken");
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_not_taken");
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, "bne_not_taken");
        run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, "bne_taken");
    endtask

    task automatic test_jumps();
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, "j");
        run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, "jal");
        run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, "jr");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, "illegal_3f");
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, "after_illegal");
    endtask

    task automatic test_random();
        logic [5:0] ops [14];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000, 6'b001010,
                6'b100011, 6'b101011, 6'b111111, 6'b000001, 6'b001111, 6'b100000, 6'b000000};
        for (int i = 0; i < 48; i++) begin
            op = ops[$urandom_range(0, 13)];
            fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
            run_instr(op, fn, 1'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), $sformatf("rand%0d_op%02h", i, op));
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] ev;
        if (retired_m == 0) begin
            run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "pre_reset");
        end
        bus.opcode = 6'b101011; bus.func = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.memWrite !== 1'b1) begin
            $display("FAIL mid_memwrite_before: got %b expected 1", bus.memWrite);
        end else begin
            passes++;
        end
        rst = 1'b1;
        #1;
        ev = mk(0,0,1,0,0,0,0,0,0,0,1,0);
        checks++;
        if (observe() !== {ev, 1'b0}) begin
            $display("FAIL mid_reset_async: got %h expected %h", observe(), {ev, 1'b0});
        end else begin
            passes++;
        end
        checks++;
        if (bus.retired !== 4'd0) begin
            $display("FAIL mid_reset_retired: got %0d expected 0", bus.retired);
        end else begin
            passes++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (observe() !== {ev, 1'b0}) begin
            $display("FAIL mid_reset_release: got %h expected %h", observe(), {ev, 1'b0});
        end else begin
            passes++;
        end
        retired_m = 0;
        pend_illegal = 1'b0;
        run_instr(6'b000000, 6'b100101, 1'b0, 0, 0, "after_mid_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_itype();
        test_branch();
        test_jumps();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences fetch, decode, execute, memory and write-back over several clocks per instruction, reusing one ALU and one memory port.
- Drives every datapath mux/enable from registered state.
- Stalls on a memory-ready handshake, flags illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register. Held stable from DECODE until FETCH.
- func  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pcWrite  out  1  PC load enable. Includes a taken branch.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- regWrite  out  1  register file write enable.
- regIn  out  2  destination register: 0 = rt, 1 = rd, 2 = $31.
- toReg  out  2  write-back data: 0 = ALUOut, 1 = MDR, 2 = PC.
- pcIn  out  2  next-PC source: 0 = ALU result, 1 = jump target, 2 = rs, 3 = ALUOut (branch target).
- aluSrcA  out  1  0 = PC, 1 = rs.
- aluSrcB  out  2  0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = imm<<2.
- ALUcntrl  out  2  0 = add, 1 = sub, 2 = decode func, 3 = slt.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: state = FETCH, retired = 0, illegal = 0. While in reset, outputs take their FETCH values.
- Outputs are Moore-decoded from state. Exception: pcWrite in BRANCH = (zero XOR (opcode==000101)).
- Unlisted controls are 0 in every state.

States and outputs:
- FETCH:
  - memRead = 1, IorD = 0, aluSrcA = 0, aluSrcB = 1, ALUcntrl = 0, pcIn = 0.
  - IRWrite and pcWrite assert only when mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: aluSrcA = 0, aluSrcB = 3, ALUcntrl = 0 (precomputes branch target). Dispatches on opcode:
  - 000000 with func = 001000 -> JR.
  - 000000 otherwise -> R_EX.
  - 100011 or 101011 -> MEM_ADDR.
  - 000100 or 000101 -> BRANCH.
  - 001000 (addi) -> I_EX.
  - 001010 (slti) -> I_EX.
  - 000010 -> JUMP.
  - 000011 -> JAL.
  - any other -> FETCH, with illegal = 1 for one cycle and retired not incremented.
- MEM_ADDR: aluSrcA = 1, aluSrcB = 2, ALUcntrl = 0. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: memRead = 1, IorD = 1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: regWrite = 1, regIn = 0, toReg = 1. Goes to FETCH.
- MEM_WR: memWrite = 1, IorD = 1. Waits for mem_ready, then goes to FETCH.
- R_EX: aluSrcA = 1, aluSrcB = 0, ALUcntrl = 2. Goes to R_WB.
- R_WB: regWrite = 1, regIn = 1, toReg = 0. Goes to FETCH.
- I_EX: aluSrcA = 1, aluSrcB = 2, ALUcntrl = 0 for addi, 3 for slti. Goes to I_WB.
- I_WB: regWrite = 1, regIn = 0, toReg = 0. Goes to FETCH.
- BRANCH: aluSrcA = 1, aluSrcB = 0, ALUcntrl = 1, pcIn = 3, pcWrite per the rule above. Goes to FETCH.
- JUMP: pcWrite = 1, pcIn = 1. Goes to FETCH.
- JAL: pcWrite = 1, pcIn = 1, regWrite = 1, regIn = 2, toReg = 2. Goes to FETCH.
  - PC here is already PC+4, so the stored link is the return address.
- JR: pcWrite = 1, pcIn = 2. Goes to FETCH.

Instruction completion and latency:
- retired increments by 1 on each transition into FETCH from a last state: MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JAL, JR.
- retired wraps modulo 2^CNT_W.
- Cycles per instruction with zero memory wait: R-type 4, addi/slti 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3.
- Each mem_ready = 0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Strobes (memRead/memWrite) stay asserted for the whole wait.

Edge cases:
- mem_ready is ignored in all non-memory states.
- rst asserted mid-instruction: immediate return to FETCH. No partial write-back occurs after reset; regWrite and memWrite drop asynchronously.
- Unused state encodings -> FETCH.

Test Plan:
- Reset, then hold mem_ready = 1 and opcode = 000000, func = 100000: state sequence FETCH, DECODE, R_EX, R_WB. regWrite = 1 with regIn = 1 in the 4th cycle; retired = 1 after cycle 4.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD: memRead and IorD held high for 3 cycles; MEM_WB has toReg = 1; total 7 cycles; retired +1.
- beq (000100), zero = 1 -> pcWrite = 1 with pcIn = 3 in cycle 3. Repeat with zero = 0 -> pcWrite = 0. bne (000101) inverts both results.
- jal (000011): cycle 3 has pcWrite = 1, pcIn = 1, regWrite = 1, regIn = 2, toReg = 2. jr (opcode 0, func 001000): pcIn = 2, regWrite never asserted.
- opcode 111111: illegal pulses one cycle after DECODE, next state FETCH, retired unchanged.
- Assert rst during MEM_WR with mem_ready = 0: memWrite drops the same cycle; after release, FETCH outputs appear and retired = 0.
